axis_row_pack_fifo: RTL and testbench

Packs narrow AXI-Stream beats of fixed-width activation elements into full MAC-array rows (`ELEM_W*MAC_NUM` bits) and buffers them in a `DEPTH`-entry FIFO.
It sits between the AXIS DMA input and the MAC array.
Compared with the previous preload FIFO it adds:
- generic element width and elements-per-beat;
- full valid/ready handshakes on both sides;
- per-row length latching;
- zero-fill of unused elements;
- `tlast`-driven partial-row flush.

---
 rtl/axis_row_pack_fifo.sv | 99 +++++++++
 tb/tb_axis_row_pack_fifo.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_row_pack_fifo.sv
// axis_row_pack_fifo: packs narrow AXIS beats of fixed-width elements into full MAC rows
// and queues them in a DEPTH-row FIFO with valid/ready on both sides.
module axis_row_pack_fifo #(
    parameter int DATA_W  = 32,
    parameter int ELEM_W  = 5,
    parameter int MAC_NUM = 256,
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [LEN_W-1:0]            row_len,
    input  logic [DATA_W-1:0]           s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [ELEM_W*MAC_NUM-1:0]   row_out,
    output logic                        row_last,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [$clog2(DEPTH):0]      fifo_cnt,
    output logic                        fifo_empty,
    output logic                        fifo_full
);
    localparam int EPB   = DATA_W / ELEM_W;
    localparam int ROW_W = ELEM_W * MAC_NUM;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int FW    = $clog2(MAC_NUM + EPB);
    localparam int MW    = $clog2(MAC_NUM + 1);

    logic [ROW_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0] last_flag;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [FW-1:0]    fill_cnt;
    logic [MW-1:0]    cur_len, len_c, len;
    logic [ROW_W-1:0] row_nxt;
    logic             push, pop, commit;
    logic             unused_bits;

    assign len_c = (row_len == '0 || int'(row_len) > MAC_NUM) ? MW'(MAC_NUM) : MW'(row_len);
    assign len = (fill_cnt == '0) ? len_c : cur_len;
    assign pop = row_valid & row_ready;
    assign s_axis_tready = ~rst & ~clear & (~fifo_full | pop);
    assign push = s_axis_tvalid & s_axis_tready;
    assign commit = push & ((int'(fill_cnt) + EPB >= int'(len)) | s_axis_tlast);
    assign fifo_empty = fifo_cnt == '0;
    assign fifo_full = fifo_cnt == CW'(DEPTH);
    assign row_valid = ~fifo_empty;
    assign row_out = mem[rd_ptr];
    assign row_last = last_flag[rd_ptr];
    assign unused_bits = ^s_axis_tdata;

    // A row's first beat starts from an all-zero slot so no stale data survives a commit
    always_comb begin
        row_nxt = (fill_cnt == '0) ? '0 : mem[wr_ptr];
        for (int j = 0; j < EPB; j++)
            if (int'(fill_cnt) + j < MAC_NUM)
                row_nxt[ELEM_W*(int'(fill_cnt)+j) +: ELEM_W] =
                    (int'(fill_cnt) + j < int'(len)) ? s_axis_tdata[ELEM_W*j +: ELEM_W] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= row_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            fill_cnt  <= '0;
            cur_len   <= '0;
            last_flag <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            fill_cnt <= '0;
            cur_len  <= '0;
        end else begin
            if (push && fill_cnt == '0) cur_len <= len_c;
            if (commit) begin
                wr_ptr            <= wr_ptr + 1'b1;
                fill_cnt          <= '0;
                last_flag[wr_ptr] <= s_axis_tlast;
            end else if (push) begin
                fill_cnt <= fill_cnt + FW'(EPB);
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (commit != pop) fifo_cnt <= commit ? fifo_cnt + 1'b1 : fifo_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_row_pack_fifo.sv
// tb_axis_row_pack_fifo: randomized and directed checks of row packing, FIFO flow control,
// tlast flush and clear against an element-list reference model.
module tb_axis_row_pack_fifo;
    localparam int DATA_W  = 32;
    localparam int ELEM_W  = 5;
    localparam int MAC_NUM = 256;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 12;
    localparam int EPB     = DATA_W / ELEM_W;
    localparam int ROW_W   = ELEM_W * MAC_NUM;

    logic                   clk, rst, clear;
    logic [LEN_W-1:0]       row_len;
    logic [DATA_W-1:0]      s_axis_tdata;
    logic                   s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [ROW_W-1:0]       row_out;
    logic                   row_last, row_valid, row_ready;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic                   fifo_empty, fifo_full;

    axis_row_pack_fifo #(.DATA_W(DATA_W), .ELEM_W(ELEM_W), .MAC_NUM(MAC_NUM), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .clear(clear), .row_len(row_len),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready), .row_out(row_out), .row_last(row_last), .row_valid(row_valid),
        .row_ready(row_ready), .fifo_cnt(fifo_cnt), .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: committed rows in order, plus the element list of the row being built
    logic [ROW_W-1:0] exp_q[$];
    logic             exp_last[$];
    int               m_elems[$];
    int               m_len = 0;

    function automatic int clamp(input int rl);
        return (rl == 0 || rl > MAC_NUM) ? MAC_NUM : rl;
    endfunction

    function automatic int elem(input logic [ROW_W-1:0] r, input int k);
        return int'(r[ELEM_W*k +: ELEM_W]);
    endfunction

    task automatic model_beat(input logic [DATA_W-1:0] d, input logic l);
        logic [ROW_W-1:0] r;
        if (m_elems.size() == 0) m_len = clamp(int'(row_len));
        for (int j = 0; j < EPB; j++) m_elems.push_back(int'(d[ELEM_W*j +: ELEM_W]));
        if (m_elems.size() >= m_len || l) begin
            r = '0;
            for (int k = 0; k < m_len && k < m_elems.size(); k++) r[ELEM_W*k +: ELEM_W] = ELEM_W'(m_elems[k]);
            exp_q.push_back(r);
            exp_last.push_back(l);
            m_elems.delete();
        end
    endtask

    // One clock: drive at the falling edge, observe handshakes before the rising edge
    task automatic tick(input logic v, input logic [DATA_W-1:0] d, input logic l, input logic rr,
                        input logic clr, output logic acc, output logic popd,
                        output logic [ROW_W-1:0] orow, output logic olast);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        row_ready     = rr;
        clear         = clr;
        #1;
        acc   = s_axis_tvalid & s_axis_tready;
        popd  = row_valid & row_ready & ~clr;
        orow  = row_out;
        olast = row_last;
        if (clr) begin
            exp_q.delete();
            exp_last.delete();
            m_elems.delete();
        end else if (acc) begin
            model_beat(d, l);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; clear = 1'b0; row_len = '0; s_axis_tdata = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; row_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_axis_tready, row_valid, fifo_empty, fifo_full, row_last} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00100", {s_axis_tready, row_valid, fifo_empty, fifo_full, row_last});
        end
        checks++;
        if (fifo_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
        checks++;
        if (row_out !== '0) begin failures++; $display("FAIL reset_row got=%h exp=0", row_out[63:0]); end
        rst = 1'b0;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_release_tready got=%b exp=1", s_axis_tready); end
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [DATA_W-1:0] d1, d2;
        logic acc1, acc2, popd, olast;
        logic [ROW_W-1:0] orow, er;
        d1 = '0; d2 = '0;
        for (int j = 0; j < EPB; j++) begin
            d1[ELEM_W*j +: ELEM_W] = ELEM_W'(j + 1);
            d2[ELEM_W*j +: ELEM_W] = ELEM_W'(j + 7);
        end
        row_len = 12;
        tick(1, d1, 0, 0, 0, acc1, popd, orow, olast);
        checks++;
        if (fifo_cnt !== 0) begin failures++; $display("FAIL basic_partial_cnt got=%0d exp=0", fifo_cnt); end
        tick(1, d2, 0, 0, 0, acc2, popd, orow, olast);
        checks++;
        if ({acc1, acc2} !== 2'b11) begin failures++; $display("FAIL basic_accept got=%b exp=11", {acc1, acc2}); end
        checks++;
        if (fifo_cnt !== 1 || row_valid !== 1'b1) begin failures++; $display("FAIL basic_cnt got=%0d valid=%b exp=1", fifo_cnt, row_valid); end
        checks++;
        if (elem(row_out, 0) != 1 || elem(row_out, 11) != 12 || elem(row_out, 12) != 0 || elem(row_out, 255) != 0 || row_last !== 1'b0) begin
            failures++;
            $display("FAIL basic_elems got=%0d,%0d,%0d last=%b exp=1,12,0 last=0", elem(row_out, 0), elem(row_out, 11), elem(row_out, 12), row_last);
        end
        tick(0, '0, 0, 1, 0, acc1, popd, orow, olast);
        er = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++;
        if (popd !== 1'b1 || orow !== er) begin failures++; $display("FAIL basic_pop got=%h exp=%h", orow[63:0], er[63:0]); end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
        checks++;
        if (fifo_cnt !== 0 || fifo_empty !== 1'b1) begin failures++; $display("FAIL basic_drain got=%0d exp=0", fifo_cnt); end
    endtask

    task automatic test_allones;
        logic acc, popd, olast, ok;
        logic [ROW_W-1:0] orow, er;
        row_len = 8;
        tick(1, '1, 0, 0, 0, acc, popd, orow, olast);
        tick(1, '1, 0, 0, 0, acc, popd, orow, olast);
        ok = 1'b1;
        for (int k = 0; k < MAC_NUM; k++) if (elem(row_out, k) != (k < 8 ? 31 : 0)) ok = 1'b0;
        checks++;
        if (!ok || fifo_cnt !== 1) begin failures++; $display("FAIL allones_elems got=%h cnt=%0d exp=ffffffffff cnt=1", row_out[63:0], fifo_cnt); end
        tick(0, '0, 0, 1, 0, acc, popd, orow, olast);
        er = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++;
        if (popd !== 1'b1 || orow !== er) begin failures++; $display("FAIL allones_pop got=%h exp=%h", orow[63:0], er[63:0]); end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
    endtask

    task automatic test_full;
        logic acc, popd, olast;
        logic [ROW_W-1:0] orow, er;
        row_len = 6;
        for (int i = 0; i < DEPTH; i++) tick(1, $urandom(), 0, 0, 0, acc, popd, orow, olast);
        checks++;
        if (fifo_cnt !== DEPTH || fifo_full !== 1'b1 || s_axis_tready !== 1'b0) begin
            failures++;
            $display("FAIL full_state got cnt=%0d full=%b tready=%b exp cnt=4 full=1 tready=0", fifo_cnt, fifo_full, s_axis_tready);
        end
        tick(1, $urandom(), 0, 1, 0, acc, popd, orow, olast);
        er = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++;
        if (acc !== 1'b1 || popd !== 1'b1 || orow !== er) begin
            failures++;
            $display("FAIL full_push_pop got acc=%b pop=%b row=%h exp acc=1 pop=1 row=%h", acc, popd, orow[63:0], er[63:0]);
        end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
        checks++;
        if (fifo_cnt !== DEPTH) begin failures++; $display("FAIL full_cnt_hold got=%0d exp=4", fifo_cnt); end
        for (int i = 0; i < DEPTH; i++) begin
            tick(0, '0, 0, 1, 0, acc, popd, orow, olast);
            er = (exp_q.size() > 0) ? exp_q[0] : 'x;
            checks++;
            if (popd !== 1'b1 || orow !== er) begin failures++; $display("FAIL full_drain_%0d got=%h exp=%h", i, orow[63:0], er[63:0]); end
            if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
        end
        checks++;
        if (fifo_cnt !== 0 || fifo_empty !== 1'b1) begin failures++; $display("FAIL full_empty got=%0d exp=0", fifo_cnt); end
    endtask

    task automatic test_tlast;
        logic [DATA_W-1:0] d0, da, db;
        logic acc, popd, olast;
        logic [ROW_W-1:0] orow, er;
        d0 = $urandom(); da = $urandom(); db = $urandom();
        row_len = 256;
        tick(1, d0, 1, 0, 0, acc, popd, orow, olast);
        checks++;
        if (fifo_cnt !== 1 || row_last !== 1'b1 || row_out[ROW_W-1:EPB*ELEM_W] !== '0 || row_out[EPB*ELEM_W-1:0] !== d0[EPB*ELEM_W-1:0]) begin
            failures++;
            $display("FAIL tlast_row got cnt=%0d last=%b low=%h exp cnt=1 last=1 low=%h", fifo_cnt, row_last, row_out[29:0], d0[29:0]);
        end
        row_len = 12;
        tick(1, da, 0, 0, 0, acc, popd, orow, olast);
        tick(1, db, 0, 0, 0, acc, popd, orow, olast);
        checks++;
        if (fifo_cnt !== 2) begin failures++; $display("FAIL tlast_cnt got=%0d exp=2", fifo_cnt); end
        for (int i = 0; i < 2; i++) begin
            tick(0, '0, 0, 1, 0, acc, popd, orow, olast);
            er = (exp_q.size() > 0) ? exp_q[0] : 'x;
            checks++;
            if (popd !== 1'b1 || orow !== er || olast !== (i == 0)) begin
                failures++;
                $display("FAIL tlast_pop_%0d got last=%b row=%h exp last=%b row=%h", i, olast, orow[63:0], i == 0, er[63:0]);
            end
            if (i == 1) begin
                checks++;
                if (orow[EPB*ELEM_W-1:0] !== da[EPB*ELEM_W-1:0]) begin failures++; $display("FAIL tlast_next_start got=%h exp=%h", orow[29:0], da[29:0]); end
            end
            if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
        end
    endtask

    task automatic test_clear;
        logic [DATA_W-1:0] d4, d5;
        logic acc, popd, olast;
        logic [ROW_W-1:0] orow, er;
        d4 = $urandom(); d5 = $urandom();
        row_len = 12;
        tick(1, $urandom(), 0, 0, 0, acc, popd, orow, olast);
        tick(1, $urandom(), 0, 0, 0, acc, popd, orow, olast);
        tick(1, $urandom(), 0, 0, 1, acc, popd, orow, olast);
        checks++;
        if (acc !== 1'b0 || fifo_cnt !== 0 || fifo_empty !== 1'b1) begin
            failures++;
            $display("FAIL clear_flush got acc=%b cnt=%0d exp acc=0 cnt=0", acc, fifo_cnt);
        end
        tick(1, $urandom(), 0, 0, 0, acc, popd, orow, olast);
        tick(0, '0, 0, 0, 1, acc, popd, orow, olast);
        tick(1, d4, 0, 0, 0, acc, popd, orow, olast);
        checks++;
        if (fifo_cnt !== 0) begin failures++; $display("FAIL clear_midrow_cnt got=%0d exp=0", fifo_cnt); end
        tick(1, d5, 0, 0, 0, acc, popd, orow, olast);
        checks++;
        if (fifo_cnt !== 1 || row_out[29:0] !== d4[29:0] || row_out[59:30] !== d5[29:0] || row_out[ROW_W-1:60] !== '0) begin
            failures++;
            $display("FAIL clear_restart got cnt=%0d low=%h exp cnt=1 low=%h", fifo_cnt, row_out[59:0], {d5[29:0], d4[29:0]});
        end
        tick(0, '0, 0, 1, 0, acc, popd, orow, olast);
        er = (exp_q.size() > 0) ? exp_q[0] : 'x;
        checks++;
        if (popd !== 1'b1 || orow !== er) begin failures++; $display("FAIL clear_pop got=%h exp=%h", orow[63:0], er[63:0]); end
        if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
    endtask

    task automatic test_stream;
        logic acc, popd, olast, v, l, rr, el;
        logic [ROW_W-1:0] orow, er;
        int popped = 0;
        int cyc = 0;
        while (popped < 10 && cyc < 3000) begin
            cyc++;
            row_len = ($urandom_range(0, 15) == 0) ? LEN_W'($urandom_range(256, 300)) : LEN_W'($urandom_range(1, 24));
            v  = $urandom_range(0, 4) != 0;
            l  = $urandom_range(0, 7) == 0;
            rr = $urandom_range(0, 1);
            tick(v, $urandom(), l, rr, 0, acc, popd, orow, olast);
            if (popd) begin
                er = (exp_q.size() > 0) ? exp_q[0] : 'x;
                el = (exp_last.size() > 0) ? exp_last[0] : 1'bx;
                checks++;
                if (exp_q.size() == 0 || orow !== er || olast !== el) begin
                    failures++;
                    $display("FAIL stream_row_%0d got last=%b row=%h exp last=%b row=%h", popped, olast, orow[63:0], el, er[63:0]);
                end
                if (exp_q.size() > 0) begin void'(exp_q.pop_front()); void'(exp_last.pop_front()); end
                popped++;
            end
            checks++;
            if (int'(fifo_cnt) != exp_q.size() || fifo_cnt > DEPTH) begin
                failures++;
                $display("FAIL stream_cnt cyc=%0d got=%0d exp=%0d", cyc, fifo_cnt, exp_q.size());
            end
        end
        checks++;
        if (popped < 10) begin failures++; $display("FAIL stream_timeout got=%0d rows exp=10", popped); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_allones();
        test_full();
        test_tlast();
        test_clear();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
